// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box definitions: forward/inverse substitution tables,
// lookup helpers and the SubBytes engine state encoding.
package aes_sbox_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward S-box, row-major by high nibble (entry 0x00 first)
    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box, same layout as the forward table
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational AES S-box lane with forward/inverse select.
// Shared between the SubBytes engine and key expansion (SubWord).
module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_inverse,
    output logic [7:0] o_byte
);

    assign o_byte = i_inverse ? sbox_inv(i_byte) : sbox_fwd(i_byte);

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes / InvSubBytes engine: LANES S-box lanes process
// one slice of the state per beat until the whole state is substituted.
// The work buffer is shifted down one slice per beat while substituted
// bytes enter at the top, so after BEATS beats every byte sits back at
// its original position without any variable-index muxing.
module sub_bytes_engine
    import aes_sbox_pkg::*;
#(
    parameter int STATE_BYTES = AES_STATE_BYTES,
    parameter int LANES       = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inverse,
    input  logic [8*STATE_BYTES-1:0] in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*STATE_BYTES-1:0] out_state,
    output logic                     busy
);

    localparam bit BAD_CFG = (LANES <= 0) ? 1'b1 : ((STATE_BYTES % LANES) != 0);
    localparam int BEATS   = BAD_CFG ? 1 : STATE_BYTES / LANES;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STATE_W = 8 * STATE_BYTES;
    localparam int LANE_W  = 8 * LANES;

    generate
        if (BAD_CFG) begin : g_bad_cfg
            $fatal(1, "sub_bytes_engine: STATE_BYTES must be a nonzero multiple of LANES");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [STATE_W-1:0]   r_work;
    logic [STATE_W-1:0]   r_result;
    logic [STATE_W-1:0]   w_work_next;
    logic                 r_inverse;
    logic [LANE_W-1:0]    w_lane_in;
    logic [LANE_W-1:0]    w_lane_out;
    logic                 w_accept;
    logic                 w_last_beat;

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
    assign w_lane_in   = r_work[LANE_W-1:0];

    // Parallel S-box lanes always look at the lowest slice of the work buffer
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            aes_sbox_lane u_lane (
                .i_byte    (w_lane_in[8*l +: 8]),
                .i_inverse (r_inverse),
                .o_byte    (w_lane_out[8*l +: 8])
            );
        end

        if (BEATS == 1) begin : g_single_beat
            assign w_work_next = w_lane_out;
        end else begin : g_multi_beat
            assign w_work_next = {w_lane_out, r_work[STATE_W-1:LANE_W]};
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, run BEATS beats, hold result until taken
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = BUSY;
            BUSY: if (w_last_beat) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch the request, shift one slice per beat, publish on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_result  <= '0;
            r_inverse <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work    <= in_state;
                        r_inverse <= in_inverse;
                        r_cnt     <= '0;
                    end
                end
                BUSY: begin
                    r_work <= w_work_next;
                    if (w_last_beat) begin
                        r_result <= w_work_next;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY) || (r_state == DONE);
    assign out_state = r_result;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Testbench for sub_bytes_engine. The main instance uses 4 lanes; two
// extra instances (1 and 16 lanes) share the request inputs during the
// table sweep. Expected values come from an S-box model built with
// GF(2^8) arithmetic plus the affine transform, and from literal vectors.
module tb_sub_bytes_engine;

    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inValidAux;
    logic         inInverse;
    logic [127:0] inState;
    logic         outReady;
    logic         auxReady;
    logic         inReady, outValid, busy;
    logic [127:0] outState;
    logic         inReady1, outValid1, busy1;
    logic [127:0] outState1;
    logic         inReady16, outValid16, busy16;
    logic [127:0] outState16;

    logic [7:0]   refFwd [256];
    logic [7:0]   refInv [256];
    logic [127:0] cap1, cap16;
    int           done1 = 0;
    int           done16 = 0;
    int           compared = 0;
    int           mismatched = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    sub_bytes_engine #(.STATE_BYTES(16), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .in_inverse(inInverse), .in_state(inState), .out_valid(outValid),
        .out_ready(outReady), .out_state(outState), .busy(busy)
    );

    sub_bytes_engine #(.STATE_BYTES(16), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidAux), .in_ready(inReady1),
        .in_inverse(inInverse), .in_state(inState), .out_valid(outValid1),
        .out_ready(auxReady), .out_state(outState1), .busy(busy1)
    );

    sub_bytes_engine #(.STATE_BYTES(16), .LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidAux), .in_ready(inReady16),
        .in_inverse(inInverse), .in_state(inState), .out_valid(outValid16),
        .out_ready(auxReady), .out_state(outState16), .busy(busy16)
    );

    // Capture each result the auxiliary instances hand off (their consumer is always ready)
    always @(posedge clk) begin
        if (outValid1) begin
            cap1  <= outState1;
            done1 <= done1 + 1;
        end
        if (outValid16) begin
            cap16  <= outState16;
            done16 <= done16 + 1;
        end
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Build reference tables: multiplicative inverse (x^254) then affine map
    function automatic void buildModel();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = 8'h01;
            logic [7:0] s;
            for (int k = 0; k < 254; k++) y = gmul(y, 8'(x));
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            refFwd[x] = s;
            refInv[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] refSub(input logic [127:0] st, input bit inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? refInv[st[8*i +: 8]] : refFwd[st[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One comparison: count it, and report tag/observed/expected on failure
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for readiness, then present one request for a single cycle
    task automatic applyStimulus(input logic [127:0] st, input bit inv, input bit aux);
        int n = 0;
        while (!(inReady && (!aux || (inReady1 && inReady16))) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("ready_timeout", 128'd0, 128'd1);
        inState    = st;
        inInverse  = inv;
        inValid    = 1'b1;
        inValidAux = aux;
        step();
        inValid    = 1'b0;
        inValidAux = 1'b0;
    endtask

    // Wait for out_valid, check latency and data; if the consumer is ready, check the handoff
    task automatic checkOutput(input logic [127:0] exp, input int lat, input string tag);
        int n = 0;
        while (!outValid && n < 100) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_data"}, outState, exp);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        if (outReady) begin
            step();
            check({tag, "_handoff"}, {126'd0, outValid, inReady}, {126'd0, 1'b0, 1'b1});
            check({tag, "_hold"}, outState, exp);
        end
    endtask

    // Wait (bounded) for both auxiliary instances to hand off, then compare them
    task automatic checkAux(input int start1, input int start16, input logic [127:0] exp, input string tag);
        int n = 0;
        while ((done1 == start1 || done16 == start16) && n < 100) begin
            step();
            n++;
        end
        check({tag, "_lanes1"}, cap1, exp);
        check({tag, "_lanes16"}, cap16, exp);
    endtask

    // Directed sequence
    initial begin
        logic [127:0] st, exp, fres, other;
        int a1, a16;

        buildModel();
        rst_n      = 1'b0;
        inValid    = 1'b0;
        inValidAux = 1'b0;
        inInverse  = 1'b0;
        inState    = '0;
        outReady   = 1'b1;
        auxReady   = 1'b1;

        // Reset values
        #1;
        check("reset_in_ready", 128'(inReady), 128'd1);
        check("reset_out_valid", 128'(outValid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_out_state", outState, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // FIPS-197 round-1 vector forward, then back through the inverse
        applyStimulus(128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0, 1'b0);
        checkOutput(128'h3052411ee55db4b8f198bfe0ae1127d4, BEATS, "fips_fwd");
        applyStimulus(128'h3052411ee55db4b8f198bfe0ae1127d4, 1'b1, 1'b0);
        checkOutput(128'h0848f8e92a8dc69a2be2f4a0bee33d19, BEATS, "fips_inv");

        // Spot table entries in known byte positions
        st = rand128();
        st[31:0] = 32'hb6645000;
        applyStimulus(st, 1'b0, 1'b0);
        checkOutput(refSub(st, 1'b0), BEATS, "spot_fwd");
        check("spot_fwd_bytes", {96'd0, outState[31:0]}, {96'd0, 32'h4e435363});
        st = rand128();
        st[15:0] = 16'h1663;
        applyStimulus(st, 1'b1, 1'b0);
        checkOutput(refSub(st, 1'b1), BEATS, "spot_inv");
        check("spot_inv_bytes", {112'd0, outState[15:0]}, {112'd0, 16'hff00});

        // Full table sweep on all three lane counts, with forward/inverse round trip
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(t * 16 + i);
            a1 = done1; a16 = done16;
            applyStimulus(st, 1'b0, 1'b1);
            exp = refSub(st, 1'b0);
            checkOutput(exp, BEATS, "sweep_fwd");
            checkAux(a1, a16, exp, "sweep_fwd");
            fres = exp;
            a1 = done1; a16 = done16;
            applyStimulus(fres, 1'b1, 1'b1);
            checkOutput(st, BEATS, "sweep_roundtrip");
            checkAux(a1, a16, st, "sweep_roundtrip");
        end

        // Random transactions in random modes
        for (int r = 0; r < 8; r++) begin
            st = rand128();
            applyStimulus(st, 1'($urandom_range(0, 1)), 1'b0);
            checkOutput(refSub(st, inInverse), BEATS, "random");
        end

        // Backpressure: result and flags hold while the consumer stalls
        outReady = 1'b0;
        st = rand128();
        exp = refSub(st, 1'b0);
        applyStimulus(st, 1'b0, 1'b0);
        checkOutput(exp, BEATS, "bp");
        for (int c = 0; c < 10; c++) begin
            inValid   = 1'b1;
            inState   = rand128();
            inInverse = 1'($urandom_range(0, 1));
            step();
            check("bp_out_valid", 128'(outValid), 128'd1);
            check("bp_out_state", outState, exp);
            check("bp_in_ready", 128'(inReady), 128'd0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        step();
        check("bp_release", {126'd0, outValid, inReady}, {126'd0, 1'b0, 1'b1});
        check("bp_release_hold", outState, exp);

        // Inputs changing mid-transaction have no effect on the latched request
        st = rand128();
        exp = refSub(st, 1'b0);
        applyStimulus(st, 1'b0, 1'b0);
        step();
        other = rand128();
        inState   = other;
        inInverse = 1'b1;
        checkOutput(exp, BEATS - 1, "modechg");
        inInverse = 1'b0;

        // Asynchronous reset in the middle of BUSY discards the transaction
        st = rand128();
        applyStimulus(st, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 128'(outValid), 128'd0);
        check("midreset_out_state", outState, 128'd0);
        check("midreset_in_ready", 128'(inReady), 128'd1);
        check("midreset_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        st = rand128();
        applyStimulus(st, 1'b1, 1'b0);
        checkOutput(refSub(st, 1'b1), BEATS, "postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
